// File: rtl/mlaccel_insn_fetch.sv
// mlaccel_insn_fetch
//
// Instruction fetch and issue stage that sits between the host command
// state machine and mlaccel_compute. A start pulse begins reading 32-bit
// instruction words from main memory over the shared smem port. HALT and
// JUMP opcodes are consumed here and never forwarded. All other words are
// buffered in a small FIFO and handed to the compute unit over a
// valid/ready handshake.
//
// Ports
//   clock       system clock, all logic on posedge
//   reset       synchronous, active-high
//   start       one-cycle pulse: begin fetching at addr (ignored while busy)
//   stop        one-cycle pulse: abort the running program (wins over start)
//   addr        start address, sampled only on an accepted start
//   busy        high from accepted start until fully idle again
//   smem_valid  memory read request, held until smem_ready
//   smem_ready  one-cycle pulse: smem_data valid, request retired
//   smem_addr   word address of the request, stable while smem_valid
//   smem_data   instruction word, valid with smem_ready
//   comp_valid  FIFO head valid
//   comp_ready  compute accepts the head when comp_valid && comp_ready
//   comp_insn   FIFO head instruction, holds its last value when empty
module mlaccel_insn_fetch #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] OP_HALT    = 7'h00,
  parameter logic [6:0] OP_JUMP    = 7'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        smem_valid,
  input  logic        smem_ready,
  output logic [15:0] smem_addr,
  input  logic [31:0] smem_data,
  output logic        comp_valid,
  input  logic        comp_ready,
  output logic [31:0] comp_insn
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ABORT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      pc;
  logic [15:0]      pc_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_pop;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [31:0]      head_nxt;
  logic             retire;
  logic             pop;
  logic             push;
  logic             clear;
  logic             issue;
  logic             pending_after;

  assign comp_valid = (count != '0);
  // smem_ready with nothing outstanding is a protocol error and is ignored.
  assign retire     = smem_valid && smem_ready;
  assign pop        = comp_valid && comp_ready;
  assign count_pop  = count - CNT_W'(pop);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  // A request still in flight after this edge; the arbiter has committed to
  // it, so it is never withdrawn early.
  assign pending_after = smem_valid && !smem_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_nxt = FETCH;
          pc_nxt    = addr;
        end
      end
      FETCH: begin
        if (stop) begin
          // a word retiring in this same cycle is discarded
          clear     = 1'b1;
          state_nxt = pending_after ? ABORT : IDLE;
        end else if (retire) begin
          if (smem_data[6:0] == OP_HALT) begin
            state_nxt = DRAIN;
          end else if (smem_data[6:0] == OP_JUMP) begin
            pc_nxt = smem_data[31:16];
          end else begin
            push   = 1'b1;
            pc_nxt = pc + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (stop) begin
          clear     = 1'b1;
          state_nxt = pending_after ? ABORT : IDLE;
        end else if (count_pop == '0) begin
          state_nxt = IDLE;
        end
      end
      ABORT: begin
        if (retire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    count_nxt = clear ? '0 : (count_pop + CNT_W'(push));

    // Issue gating counts the buffered words plus the request that would be
    // outstanding, so the FIFO can never overflow. The new request is
    // launched in the same edge that retires the previous one.
    issue = (state_nxt == FETCH) && !pending_after && (count_nxt < DEPTH_C);

    // comp_insn is registered: it tracks the next head, bypasses a push into
    // an empty FIFO, and holds the last value when the FIFO goes empty.
    if (count_nxt == '0) begin
      head_nxt = comp_insn;
    end else if (count_pop == '0) begin
      head_nxt = smem_data;
    end else begin
      head_nxt = fifo_mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      smem_valid <= 1'b0;
      smem_addr  <= '0;
      pc         <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      comp_insn  <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      pc        <= pc_nxt;
      count     <= count_nxt;
      comp_insn <= head_nxt;
      if (issue) begin
        smem_valid <= 1'b1;
        smem_addr  <= pc_nxt;
      end else if (retire) begin
        smem_valid <= 1'b0;
      end
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr_nxt;
        wr_ptr <= wr_ptr + PTR_W'(push);
      end
    end
  end

  // Buffer storage carries data only and needs no reset.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= smem_data;
  end

endmodule

// File: tb/tb_mlaccel_insn_fetch.sv
`timescale 1ns/1ps
module tb_mlaccel_insn_fetch;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] addr;
  logic        busy;
  logic        smem_valid;
  logic        smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        comp_valid;
  logic        comp_ready;
  logic [31:0] comp_insn;

  mlaccel_insn_fetch #(.FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .addr       (addr),
    .busy       (busy),
    .smem_valid (smem_valid),
    .smem_ready (smem_ready),
    .smem_addr  (smem_addr),
    .smem_data  (smem_data),
    .comp_valid (comp_valid),
    .comp_ready (comp_ready),
    .comp_insn  (comp_insn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] memory [0:65535];
  logic [15:0] exp_addr [$];
  logic [31:0] exp_insn [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cnt = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  int last_ret_cyc = 0;
  int mem_lat = 1;
  bit mem_hold = 0;
  bit spurious = 0;
  bit comp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Program-level model: walk the program from the start address and list
  // every word address the fetch unit must request and every instruction
  // the compute unit must receive, in order.
  task automatic build_expect(input logic [15:0] start_pc);
    logic [15:0] p;
    logic [31:0] w;
    p = start_pc;
    exp_addr.delete();
    exp_insn.delete();
    for (int i = 0; i < 64; i++) begin
      w = memory[p];
      exp_addr.push_back(p);
      if (w[6:0] == 7'h00) break;
      else if (w[6:0] == 7'h01) p = w[31:16];
      else begin
        exp_insn.push_back(w);
        p = p + 16'd1;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget, output int at_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clock); #3;
      n++;
    end while (busy && n < budget);
    check(name, busy, 0);
    at_cyc = cyc;
  endtask

  // Memory responder: answers each request after mem_lat idle cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    smem_ready = 1'b0;
    smem_data  = '0;
    forever begin
      @(negedge clock); #1;
      if (smem_ready) begin
        smem_ready = 1'b0;
        wcnt = 0;
      end else if (spurious && !smem_valid) begin
        smem_ready = 1'b1;
        smem_data  = 32'h0000_0385;
        spurious   = 1'b0;
      end else if (smem_valid && !mem_hold) begin
        if (wcnt >= mem_lat) begin
          smem_ready = 1'b1;
          smem_data  = memory[smem_addr];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Compare process: every cycle, check handshakes against the model queues
  // and the stability rules for both interfaces.
  initial begin
    logic p_cv, p_cr, p_sv, p_sr, p_flush, p_rst;
    logic [31:0] p_ci;
    logic [15:0] p_sa;
    p_cv = 0; p_cr = 0; p_sv = 0; p_sr = 0; p_flush = 1; p_rst = 1;
    p_ci = '0; p_sa = '0;
    forever begin
      @(negedge clock); #2;
      cyc++;
      if (p_cv && !p_cr && !p_flush) begin
        check("comp_hold_valid", comp_valid, 1);
        check("comp_hold_insn", comp_insn, p_ci);
      end
      if (p_sv && !p_sr && !p_rst) begin
        check("smem_hold_valid", smem_valid, 1);
        check("smem_hold_addr", smem_addr, p_sa);
      end
      if (comp_valid) comp_seen = 1;
      if (!reset && smem_valid && smem_ready) begin
        req_cnt++;
        last_ret_cyc = cyc;
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL req_extra: got request at %h, expected none", smem_addr);
        end else begin
          check("req_addr", smem_addr, exp_addr.pop_front());
        end
      end
      if (!reset && comp_valid && comp_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (exp_insn.size() == 0) begin
          total++; bad++;
          $display("FAIL insn_extra: got insn %h, expected none", comp_insn);
        end else begin
          check("comp_insn", comp_insn, exp_insn.pop_front());
        end
      end
      p_cv = comp_valid; p_cr = comp_ready; p_ci = comp_insn;
      p_sv = smem_valid; p_sr = smem_ready; p_sa = smem_addr;
      p_flush = stop || reset;
      p_rst = reset;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, x0, t_idle, last_ev, n;
    for (int i = 0; i < 65536; i++) memory[i] = '0;
    reset = 1; start = 0; stop = 0; addr = '0; comp_ready = 0;
    repeat (3) @(negedge clock);
    #3;
    check("rst_busy", busy, 0);
    check("rst_smem_valid", smem_valid, 0);
    check("rst_smem_addr", smem_addr, 0);
    check("rst_comp_valid", comp_valid, 0);
    check("rst_comp_insn", comp_insn, 0);
    @(negedge clock); reset = 0;

    // 1: straight-line program with HALT
    memory[16'h0010] = 32'h0000_0085;
    memory[16'h0011] = 32'h0000_0102;
    memory[16'h0012] = 32'h0000_0203;
    memory[16'h0013] = 32'h0000_0000;
    build_expect(16'h0010);
    check("model_t1_nreq", exp_addr.size(), 4);
    check("model_t1_insn2", exp_insn[2], 32'h0000_0203);
    comp_ready = 1; mem_lat = 1; c0 = req_cnt; x0 = xfer_cnt;
    @(negedge clock); start = 1; addr = 16'h0010;
    @(negedge clock); start = 0; addr = '0; #3;
    check("t1_first_valid", smem_valid, 1);
    check("t1_first_addr", smem_addr, 16'h0010);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle", 100, t_idle);
    check("t1_nreq", req_cnt - c0, 4);
    check("t1_nxfer", xfer_cnt - x0, 3);
    check("t1_insn_left", exp_insn.size(), 0);
    check("t1_addr_left", exp_addr.size(), 0);
    last_ev = (last_xfer_cyc > last_ret_cyc) ? last_xfer_cyc : last_ret_cyc;
    check("t1_busy_fall", (t_idle - last_ev >= 1) && (t_idle - last_ev <= 2), 1);

    // 2: backpressure from compute
    build_expect(16'h0010);
    comp_ready = 0; c0 = req_cnt; x0 = xfer_cnt;
    @(negedge clock); start = 1; addr = 16'h0010;
    @(negedge clock); start = 0;
    repeat (50) @(negedge clock);
    #3;
    check("t2_valid", comp_valid, 1);
    check("t2_head", comp_insn, 32'h0000_0085);
    check("t2_nreq", req_cnt - c0, 4);
    check("t2_no_more_req", smem_valid, 0);
    check("t2_busy", busy, 1);
    check("t2_nxfer", xfer_cnt - x0, 0);
    @(negedge clock); comp_ready = 1;
    wait_idle("t2_idle", 100, t_idle);
    check("t2_insn_left", exp_insn.size(), 0);
    check("t2_addr_left", exp_addr.size(), 0);

    // 3: JUMP redirects fetch and is not forwarded
    memory[16'h0020] = 32'h0040_0001;
    memory[16'h0040] = 32'h0000_0185;
    memory[16'h0041] = 32'h0000_0000;
    build_expect(16'h0020);
    check("model_t3_addr1", exp_addr[1], 16'h0040);
    check("model_t3_ninsn", exp_insn.size(), 1);
    mem_lat = 0; c0 = req_cnt; x0 = xfer_cnt;
    @(negedge clock); start = 1; addr = 16'h0020;
    @(negedge clock); start = 0;
    wait_idle("t3_idle", 100, t_idle);
    check("t3_nreq", req_cnt - c0, 3);
    check("t3_nxfer", xfer_cnt - x0, 1);
    check("t3_addr_left", exp_addr.size(), 0);
    check("t3_insn_left", exp_insn.size(), 0);

    // 4: self-loop JUMP ended by stop with a request in flight
    memory[16'h0000] = 32'h0000_0001;
    build_expect(16'h0000);
    mem_lat = 1; c0 = req_cnt;
    @(negedge clock); comp_seen = 0; start = 1; addr = 16'h0000;
    @(negedge clock); start = 0;
    repeat (20) @(negedge clock);
    mem_hold = 1;
    @(negedge clock); #3;
    check("t4_loop_busy", busy, 1);
    check("t4_req_pending", smem_valid, 1);
    check("t4_loop_progress", (req_cnt - c0) >= 5, 1);
    @(negedge clock); stop = 1;
    @(negedge clock); stop = 0; #3;
    check("t4_abort_busy", busy, 1);
    check("t4_abort_valid", smem_valid, 1);
    repeat (3) @(negedge clock);
    #3;
    check("t4_abort_busy_held", busy, 1);
    check("t4_abort_valid_held", smem_valid, 1);
    @(negedge clock); mem_hold = 0;
    wait_idle("t4_idle", 20, t_idle);
    check("t4_busy_after_retire", t_idle - last_ret_cyc, 1);
    check("t4_smem_idle", smem_valid, 0);
    check("t4_comp_never", comp_seen, 0);
    exp_addr.delete(); exp_insn.delete();

    // 5: start+stop together, start while busy, stray smem_ready
    c0 = req_cnt;
    @(negedge clock); start = 1; stop = 1; addr = 16'h0010;
    @(negedge clock); start = 0; stop = 0; #3;
    check("t5_ss_busy", busy, 0);
    check("t5_ss_smem", smem_valid, 0);
    repeat (3) @(negedge clock);
    #3;
    check("t5_ss_nreq", req_cnt - c0, 0);
    build_expect(16'h0010);
    c0 = req_cnt; x0 = xfer_cnt;
    @(negedge clock); start = 1; addr = 16'h0010;
    @(negedge clock); addr = 16'h1234;
    @(negedge clock); start = 0; addr = '0;
    wait_idle("t5_idle", 100, t_idle);
    check("t5_nreq", req_cnt - c0, 4);
    check("t5_addr_left", exp_addr.size(), 0);
    check("t5_insn_left", exp_insn.size(), 0);
    x0 = xfer_cnt;
    @(negedge clock); spurious = 1;
    repeat (3) @(negedge clock);
    #3;
    check("t5_stray_comp_valid", comp_valid, 0);
    check("t5_stray_busy", busy, 0);
    check("t5_stray_nxfer", xfer_cnt - x0, 0);

    // 6: reset mid-program, then a fetch that wraps the address
    build_expect(16'h0010);
    comp_ready = 0; mem_lat = 1; c0 = req_cnt;
    @(negedge clock); start = 1; addr = 16'h0010;
    @(negedge clock); start = 0;
    n = 0;
    while ((req_cnt - c0) < 2 && n < 50) begin
      @(negedge clock); #3;
      n++;
    end
    mem_hold = 1;
    check("t6_two_fetched", req_cnt - c0, 2);
    @(negedge clock); #3;
    check("t6_pre_comp_valid", comp_valid, 1);
    check("t6_pre_smem_valid", smem_valid, 1);
    check("t6_pre_smem_addr", smem_addr, 16'h0012);
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0; #3;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_smem_valid", smem_valid, 0);
    check("t6_rst_comp_valid", comp_valid, 0);
    mem_hold = 0;
    exp_addr.delete(); exp_insn.delete();
    memory[16'hFFFF] = 32'h0000_0285;
    memory[16'h0000] = 32'h0000_0000;
    build_expect(16'hFFFF);
    check("model_t6_nreq", exp_addr.size(), 2);
    check("model_t6_addr1", exp_addr[1], 16'h0000);
    comp_ready = 1; c0 = req_cnt; x0 = xfer_cnt;
    @(negedge clock); start = 1; addr = 16'hFFFF;
    @(negedge clock); start = 0;
    wait_idle("t6_idle", 100, t_idle);
    check("t6_nreq", req_cnt - c0, 2);
    check("t6_nxfer", xfer_cnt - x0, 1);
    check("t6_addr_left", exp_addr.size(), 0);
    check("t6_insn_left", exp_insn.size(), 0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlaccel_insn_fetch.md
Name: mlaccel_insn_fetch

Overview:
Instruction fetch/issue stage between the host command state machine and mlaccel_compute. On a start pulse it reads 32-bit instruction words from main memory over the shared smem port, strips control-flow opcodes (HALT, JUMP), and buffers the remaining instructions in a small FIFO. Buffered instructions go to the compute unit over a valid/ready handshake. Busy status is reported upstream for the host status command.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2)
OP_HALT, 7'h00, opcode (insn[6:0]) ending the program; never forwarded
OP_JUMP, 7'h01, opcode redirecting fetch to insn[31:16]; never forwarded

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin fetching at addr
stop  in  1  one-cycle pulse: abort the running program
addr  in  16  start address, sampled only on an accepted start
busy  out  1  high from accepted start until fully idle again
smem_valid  out  1  memory read request, held until smem_ready
smem_ready  in  1  one-cycle pulse: smem_data valid, request retired
smem_addr  out  16  word address of request; stable while smem_valid
smem_data  in  32  instruction word, valid when smem_ready
comp_valid  out  1  FIFO head valid
comp_ready  in  1  compute accepts head when comp_valid && comp_ready
comp_insn  out  32  FIFO head instruction

Behaviour:
- Reset values: busy=0, smem_valid=0, smem_addr=0, comp_valid=0, comp_insn=0. FIFO count=0, state IDLE. Reset mid-operation drops any outstanding request and all FIFO contents immediately.
- State machine states: IDLE, FETCH, DRAIN, ABORT. busy = (state != IDLE), registered.
- IDLE: start accepted → pc<=addr, state FETCH, busy=1 next cycle. stop in IDLE is ignored.
- FETCH request issue: smem_valid rises the cycle after the condition (count + outstanding) < FIFO_DEPTH holds with no request outstanding, with smem_addr=pc. At most one request is outstanding. smem_valid/smem_addr hold until smem_ready, and smem_valid drops the cycle after smem_ready.
- On smem_ready in FETCH, decode smem_data[6:0]:
  - OP_HALT → not pushed; state DRAIN.
  - OP_JUMP → not pushed; pc<=smem_data[31:16].
  - Otherwise → push smem_data; pc<=pc+1, wrapping 16'hFFFF→16'h0000.
- First fetch latency: start at cycle T gives smem_valid at T+1. smem_ready at cycle R gives comp_valid at R+1 if the FIFO was empty. Back-to-back fetches: the next smem_valid rises at R+1.
- FIFO: comp_valid = (count != 0); comp_insn = head entry, and holds its last value when empty. A pop and a push in the same cycle leave count unchanged. No overflow is possible because issue is gated by count + outstanding. comp_insn/comp_valid stay stable until accepted.
- DRAIN: no new requests. When count==0 (last entry accepted) → IDLE; busy falls the following cycle.
- stop in FETCH or DRAIN:
  - FIFO cleared the same cycle; comp_valid=0 next cycle. A comp_ready in that cycle completes the current transfer normally.
  - If no request is outstanding → IDLE.
  - If a request is outstanding → ABORT: smem_valid stays high until smem_ready, the data is discarded, then IDLE. The request is never withdrawn early, because the memory arbiter has already committed.
- start while busy is ignored. start and stop in the same cycle: stop wins, start ignored.
- smem_ready while no request is outstanding is a protocol error; it must be ignored (no push).
- A JUMP to its own address loops forever; only stop or reset ends it.

Test Plan:
1. Memory at 0x0010..0x0013 = 0x00000085, 0x00000102, 0x00000203, 0x00000000 (HALT); start addr=0x0010, comp_ready=1 → comp_insn sequence 0x00000085, 0x00000102, 0x00000203; HALT not forwarded; busy falls after the third transfer; exactly 4 smem requests.
2. Same program with comp_ready=0 for 50 cycles → comp_valid=1 with comp_insn=0x00000085 held stable; at most FIFO_DEPTH outstanding+buffered words (the 4th fetch is the HALT). Release comp_ready → remaining insns in order.
3. Word at 0x0020 = 0x00400001 (JUMP to 0x0040), 0x0040 = 0x00000185, 0x0041 = HALT; start addr=0x0020 → smem_addr sequence 0x0020, 0x0040, 0x0041; compute sees only 0x00000185.
4. Self-loop JUMP at 0x0000 (0x00000001); stop pulse while smem_valid=1 → state ABORT; smem_valid held until smem_ready, data discarded; comp_valid never asserts; busy=0 the cycle after the request retires.
5. start+stop in the same cycle from IDLE → busy stays 0 and no smem_valid. start asserted while busy with addr=0x1234 → no 0x1234 request.
6. Assert reset while 2 insns are buffered and a request is outstanding → next cycle busy=0, smem_valid=0, comp_valid=0. A following start at 0xFFFF holding 0x00000285, then HALT at 0x0000 → requests to 0xFFFF then 0x0000 (wrap).
